// File: rtl/seed_random_arb_control_path.sv
// rtl/seed_random_arb_control_path.sv - round-robin card arbiter with ack/timeout control FSM
// Optional dealt-card counter enabled by macro SEED_RANDOM_CARD_CNT_EN.
module seed_random_arb_control_path #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_cp_i,
    input  logic              rst_cp_i,
    input  logic [N_CH-1:0]   req_card_i,
    input  logic [DATA_W-1:0] rnd_data_i,
    input  logic              rnd_valid_i,
    input  logic              card_ack_i,
    output logic [1:0]        state_o,
    output logic [N_CH-1:0]   grant_o,
    output logic [DATA_W-1:0] card_o,
    output logic              card_valid_o,
    output logic              timeout_o,
    output logic [7:0]        cards_dealt_o
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  pick, cand;
    logic              found;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              tmo_hit;
    logic [N_CH-1:0]   grant_d;
    logic [DATA_W-1:0] card_d;
    logic              card_valid_d;
    logic              timeout_d;

    // Round-robin search starting one past the last served channel
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = IDX_W'((int'(last_q) + 1 + i) % N_CH);
            if (!found && req_card_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign tmo_hit = (tcnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            state_q      <= IDLE;
            last_q       <= IDX_W'(N_CH - 1);
            gidx_q       <= '0;
            tcnt_q       <= '0;
            grant_o      <= '0;
            card_o       <= '0;
            card_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gidx_q       <= gidx_d;
            tcnt_q       <= tcnt_d;
            grant_o      <= grant_d;
            card_o       <= card_d;
            card_valid_o <= card_valid_d;
            timeout_o    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (|req_card_i) state_d = ARB;
            ARB:      state_d = found ? SEND : IDLE;
            SEND:     if (rnd_valid_i) state_d = WAIT_ACK;
            WAIT_ACK: if (card_ack_i || tmo_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Ack is tested before the timeout so a coincident ack suppresses the pulse
    always_comb begin
        grant_d      = grant_o;
        card_d       = card_o;
        card_valid_d = card_valid_o;
        timeout_d    = 1'b0;
        tcnt_d       = tcnt_q;
        last_d       = last_q;
        gidx_d       = gidx_q;
        case (state_q)
            IDLE: begin
                grant_d      = '0;
                card_valid_d = 1'b0;
            end
            ARB: begin
                if (found) begin
                    grant_d = N_CH'(1) << pick;
                    gidx_d  = pick;
                end else begin
                    grant_d = '0;
                end
            end
            SEND: begin
                if (rnd_valid_i) begin
                    card_d       = rnd_data_i;
                    card_valid_d = 1'b1;
                    tcnt_d       = '0;
                end
            end
            WAIT_ACK: begin
                if (card_ack_i) begin
                    card_valid_d = 1'b0;
                    grant_d      = '0;
                    last_d       = gidx_q;
                end else if (tmo_hit) begin
                    timeout_d    = 1'b1;
                    card_valid_d = 1'b0;
                    grant_d      = '0;
                    last_d       = gidx_q;
                    tcnt_d       = '0;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                grant_d      = '0;
                card_valid_d = 1'b0;
            end
        endcase
    end

    assign state_o = state_q;

`ifdef SEED_RANDOM_CARD_CNT_EN
    logic [7:0] dealt_q;

    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            dealt_q <= '0;
        end else if (state_q == WAIT_ACK && card_ack_i) begin
            dealt_q <= dealt_q + 8'd1;
        end
    end

    assign cards_dealt_o = dealt_q;
`else
    assign cards_dealt_o = 8'd0;
`endif

endmodule

// File: tb/tb_seed_random_arb_control_path.sv
// tb/tb_seed_random_arb_control_path.sv - directed self-checking bench for seed_random_arb_control_path
module tb_seed_random_arb_control_path;

    logic       clk_cp_i;
    logic       rst_cp_i;
    logic [3:0] req_card_i;
    logic [5:0] rnd_data_i;
    logic       rnd_valid_i;
    logic       card_ack_i;
    logic [1:0] state_o;
    logic [3:0] grant_o;
    logic [5:0] card_o;
    logic       card_valid_o;
    logic       timeout_o;
    logic [7:0] cards_dealt_o;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    seed_random_arb_control_path #(
        .N_CH   (4),
        .DATA_W (6),
        .TIMEOUT(15)
    ) dut (
        .clk_cp_i     (clk_cp_i),
        .rst_cp_i     (rst_cp_i),
        .req_card_i   (req_card_i),
        .rnd_data_i   (rnd_data_i),
        .rnd_valid_i  (rnd_valid_i),
        .card_ack_i   (card_ack_i),
        .state_o      (state_o),
        .grant_o      (grant_o),
        .card_o       (card_o),
        .card_valid_o (card_valid_o),
        .timeout_o    (timeout_o),
        .cards_dealt_o(cards_dealt_o)
    );

    initial clk_cp_i = 1'b0;
    always #5 clk_cp_i = ~clk_cp_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_cp_i);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_cp_i = 1'b0;
        @(posedge clk_cp_i);
        #1;
        rst_cp_i = 1'b1;
        acks = 0;
    endtask

    function automatic logic [31:0] exp_dealt(input int n);
`ifdef SEED_RANDOM_CARD_CNT_EN
        return 32'(n % 256);
`else
        return 32'(n) & 32'd0;
`endif
    endfunction

    initial begin
        rst_cp_i    = 1'b0;
        req_card_i  = '0;
        rnd_data_i  = '0;
        rnd_valid_i = 1'b0;
        card_ack_i  = 1'b0;
        #3;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_card", 32'(card_o), 0);
        chk("rst_cv", 32'(card_valid_o), 0);
        chk("rst_to", 32'(timeout_o), 0);
        chk("rst_dealt", 32'(cards_dealt_o), 0);
        @(posedge clk_cp_i);
        #1;
        rst_cp_i = 1'b1;

        // Basic latency: card valid three cycles after request
        req_card_i  = 4'b0010;
        rnd_valid_i = 1'b1;
        rnd_data_i  = 6'd37;
        tick(1);
        chk("t1_arb_state", 32'(state_o), 1);
        chk("t1_arb_grant", 32'(grant_o), 0);
        tick(1);
        chk("t1_send_state", 32'(state_o), 2);
        chk("t1_send_grant", 32'(grant_o), 'h2);
        chk("t1_send_cv", 32'(card_valid_o), 0);
        tick(1);
        chk("t1_wait_state", 32'(state_o), 3);
        chk("t1_wait_grant", 32'(grant_o), 'h2);
        chk("t1_wait_card", 32'(card_o), 37);
        chk("t1_wait_cv", 32'(card_valid_o), 1);
        req_card_i = '0;
        card_ack_i = 1'b1;
        tick(1);
        acks++;
        card_ack_i = 1'b0;
        chk("t1_ack_state", 32'(state_o), 0);
        chk("t1_ack_cv", 32'(card_valid_o), 0);
        chk("t1_ack_grant", 32'(grant_o), 0);
        chk("t1_dealt", 32'(cards_dealt_o), exp_dealt(acks));

        // ARB with request withdrawn returns to IDLE, pointer untouched
        apply_reset();
        req_card_i = 4'b0001;
        tick(1);
        req_card_i = '0;
        tick(1);
        chk("arb_empty_state", 32'(state_o), 0);
        chk("arb_empty_grant", 32'(grant_o), 0);

        // Round robin with all channels requesting, ack held high
        card_ack_i = 1'b1;
        req_card_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            rnd_data_i = 6'(10 + k);
            tick(2);
            chk($sformatf("rr_grant%0d", k), 32'(grant_o), 32'd1 << (k % 4));
            tick(1);
            chk($sformatf("rr_wait%0d", k), 32'(state_o), 3);
            chk($sformatf("rr_card%0d", k), 32'(card_o), 32'(10 + k));
            tick(1);
            acks++;
            chk($sformatf("rr_idle%0d", k), 32'(state_o), 0);
        end
        req_card_i = '0;
        card_ack_i = 1'b0;
        chk("rr_dealt", 32'(cards_dealt_o), exp_dealt(acks));

        // Timeout on ch0, then ch1 wins next
        apply_reset();
        rnd_data_i = 6'd5;
        req_card_i = 4'b0001;
        tick(3);
        chk("to_cv_rise", 32'(card_valid_o), 1);
        chk("to_grant", 32'(grant_o), 'h1);
        req_card_i = '0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            chk($sformatf("to_quiet%0d", i), 32'({state_o, timeout_o}), 32'({2'd3, 1'b0}));
        end
        tick(1);
        chk("to_pulse", 32'(timeout_o), 1);
        chk("to_state", 32'(state_o), 0);
        chk("to_cv", 32'(card_valid_o), 0);
        chk("to_grant_clr", 32'(grant_o), 0);
        chk("to_dealt", 32'(cards_dealt_o), exp_dealt(acks));
        tick(1);
        chk("to_pulse_end", 32'(timeout_o), 0);
        req_card_i = 4'b1111;
        tick(2);
        chk("to_next_ch1", 32'(grant_o), 'h2);
        req_card_i = '0;
        tick(1);
        card_ack_i = 1'b1;
        tick(1);
        acks++;
        card_ack_i = 1'b0;
        chk("to_next_idle", 32'(state_o), 0);
        chk("to_next_dealt", 32'(cards_dealt_o), exp_dealt(acks));

        // Ack coinciding with timeout: ack wins
        req_card_i = 4'b0100;
        tick(3);
        chk("race_grant", 32'(grant_o), 'h4);
        chk("race_cv", 32'(card_valid_o), 1);
        req_card_i = '0;
        tick(14);
        chk("race_pre_state", 32'(state_o), 3);
        chk("race_pre_to", 32'(timeout_o), 0);
        card_ack_i = 1'b1;
        tick(1);
        acks++;
        card_ack_i = 1'b0;
        chk("race_state", 32'(state_o), 0);
        chk("race_to", 32'(timeout_o), 0);
        chk("race_cv", 32'(card_valid_o), 0);
        chk("race_dealt", 32'(cards_dealt_o), exp_dealt(acks));
        tick(1);
        chk("race_to_after", 32'(timeout_o), 0);

        // Asynchronous reset mid-WAIT_ACK
        req_card_i = 4'b0001;
        rnd_data_i = 6'd42;
        tick(3);
        chk("ar_pre_state", 32'(state_o), 3);
        chk("ar_pre_grant", 32'(grant_o), 'h1);
        req_card_i = '0;
        tick(2);
        rst_cp_i = 1'b0;
        #1;
        acks = 0;
        chk("ar_state", 32'(state_o), 0);
        chk("ar_grant", 32'(grant_o), 0);
        chk("ar_card", 32'(card_o), 0);
        chk("ar_cv", 32'(card_valid_o), 0);
        chk("ar_to", 32'(timeout_o), 0);
        chk("ar_dealt", 32'(cards_dealt_o), 0);
        @(posedge clk_cp_i);
        #1;
        rst_cp_i = 1'b1;
        chk("ar_to_after", 32'(timeout_o), 0);
        req_card_i = 4'b1000;
        tick(2);
        chk("ar_ch3_grant", 32'(grant_o), 'h8);
        req_card_i = '0;
        tick(1);
        card_ack_i = 1'b1;
        tick(1);
        acks++;
        card_ack_i = 1'b0;
        chk("ar_ch3_idle", 32'(state_o), 0);

        // Counter wrap after 256 acknowledged cards
        apply_reset();
        req_card_i = 4'b1111;
        card_ack_i = 1'b1;
        for (int k = 0; k < 255; k++) begin
            tick(4);
            acks++;
        end
        chk("wrap_255", 32'(cards_dealt_o), exp_dealt(acks));
        tick(4);
        acks++;
        chk("wrap_256", 32'(cards_dealt_o), exp_dealt(acks));
        req_card_i = '0;
        card_ack_i = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
